// File: rtl/seq_match_window_counter.sv
// Window match counter: groups the sampled bit stream into WIN_LEN-bit windows,
// counts 1001-detector matches per window and publishes each window's count on
// a valid/ready result port with alarm, saturation, truncation and drop flags.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no window open; the next sample becomes bit 0 of a new window
// ST_RUN   | window open; samples accumulate, close at bit WIN_LEN-1 or on en=0
module seq_match_window_counter #(
   parameter int WIN_LEN = 16,
   parameter int CNT_W   = 8,
   parameter int THRESH  = 3
) (
   input  logic             clck,
   input  logic             rst,
   input  logic             en,
   input  logic             bit_vld,
   input  logic             det,
   output logic [CNT_W-1:0] res_cnt,
   output logic             res_vld,
   input  logic             res_rdy,
   output logic             res_alarm,
   output logic             res_sat,
   output logic             res_part,
   output logic             ovf,
   output logic             busy
);

   localparam int               IDX_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;

   logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]   acc_q, acc_d;
   logic               acc_sat_q, acc_sat_d;

   logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
   logic               res_vld_q, res_vld_d;
   logic               res_alarm_q, res_alarm_d;
   logic               res_sat_q, res_sat_d;
   logic               res_part_q, res_part_d;
   logic               ovf_q, ovf_d;

   logic               sample;
   logic               win_close;
   logic               win_abort;
   logic [CNT_W-1:0]   acc_base;
   logic               sat_base;
   logic               at_max;
   logic [CNT_W-1:0]   acc_inc;
   logic               sat_inc;
   logic               pub_req;
   logic [CNT_W-1:0]   pub_cnt;
   logic               pub_sat;
   logic               pub_part;
   logic               load_ok;

   // State register.
   always_ff @(posedge clck) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a sample opens a window, en falling closes it early.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (en && bit_vld) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State-derived outputs.
   always_comb begin
      busy = (state_q == ST_RUN);
   end

   // Per-sample accumulation and window close/abort decode.
   always_comb begin
      sample    = en && bit_vld;
      // In IDLE the sample is bit 0, so accumulation restarts from zero.
      acc_base  = (state_q == ST_RUN) ? acc_q : '0;
      sat_base  = (state_q == ST_RUN) ? acc_sat_q : 1'b0;
      at_max    = (acc_base == CNT_MAX);
      acc_inc   = (det && !at_max) ? (acc_base + CNT_W'(1)) : acc_base;
      sat_inc   = sat_base | (det & at_max);
      // WIN_LEN >= 2, so the bit taken in IDLE can never be the closing bit.
      win_close = sample && (state_q == ST_RUN) && (bit_idx_q == LAST_IDX);
      win_abort = (state_q == ST_RUN) && !en;
      // A window that was just closed leaves bit_idx at 0: nothing to truncate.
      pub_req   = win_close || (win_abort && (bit_idx_q != '0));
      pub_cnt   = win_close ? acc_inc : acc_q;
      pub_sat   = win_close ? sat_inc : acc_sat_q;
      pub_part  = !win_close;
   end

   // Next values of the window accumulator.
   always_comb begin
      bit_idx_d = bit_idx_q;
      acc_d     = acc_q;
      acc_sat_d = acc_sat_q;
      if (win_abort || win_close) begin
         bit_idx_d = '0;
         acc_d     = '0;
         acc_sat_d = 1'b0;
      end else if (sample) begin
         bit_idx_d = bit_idx_q + IDX_W'(1);
         acc_d     = acc_inc;
         acc_sat_d = sat_inc;
      end
   end

   // Window accumulator registers.
   always_ff @(posedge clck) begin
      if (!rst) begin
         bit_idx_q <= '0;
         acc_q     <= '0;
         acc_sat_q <= 1'b0;
      end else begin
         bit_idx_q <= bit_idx_d;
         acc_q     <= acc_d;
         acc_sat_q <= acc_sat_d;
      end
   end

   // Result slot: load on publish if free or being consumed, otherwise drop and flag.
   always_comb begin
      res_cnt_d   = res_cnt_q;
      res_vld_d   = res_vld_q;
      res_alarm_d = res_alarm_q;
      res_sat_d   = res_sat_q;
      res_part_d  = res_part_q;
      ovf_d       = ovf_q;
      load_ok     = !res_vld_q || res_rdy;
      if (pub_req) begin
         if (load_ok) begin
            res_cnt_d   = pub_cnt;
            res_vld_d   = 1'b1;
            res_alarm_d = (pub_cnt >= THRESH_C);
            res_sat_d   = pub_sat;
            res_part_d  = pub_part;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (res_vld_q && res_rdy) begin
         res_vld_d = 1'b0;
      end
   end

   // Result registers.
   always_ff @(posedge clck) begin
      if (!rst) begin
         res_cnt_q   <= '0;
         res_vld_q   <= 1'b0;
         res_alarm_q <= 1'b0;
         res_sat_q   <= 1'b0;
         res_part_q  <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         res_cnt_q   <= res_cnt_d;
         res_vld_q   <= res_vld_d;
         res_alarm_q <= res_alarm_d;
         res_sat_q   <= res_sat_d;
         res_part_q  <= res_part_d;
         ovf_q       <= ovf_d;
      end
   end

   assign res_cnt   = res_cnt_q;
   assign res_vld   = res_vld_q;
   assign res_alarm = res_alarm_q;
   assign res_sat   = res_sat_q;
   assign res_part  = res_part_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_match_window_counter.sv
// Bench for seq_match_window_counter: two instances (default sizing and a
// narrow-counter / short-window variant) share one stimulus stream and are
// compared against a window-level reference model.
module tb_seq_match_window_counter;

   logic clck = 1'b0;
   logic rst, en, bit_vld, det, res_rdy;

   logic [7:0] res_cnt_a;
   logic       res_vld_a, res_alarm_a, res_sat_a, res_part_a, ovf_a, busy_a;
   logic [1:0] res_cnt_b;
   logic       res_vld_b, res_alarm_b, res_sat_b, res_part_b, ovf_b, busy_b;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state, index 0 = instance A (16-bit window, 8-bit count), 1 = instance B.
   int WINS [2] = '{16, 6};
   int MAXC [2] = '{255, 3};
   int THR      = 3;
   int nbits  [2];
   int nmatch [2];
   bit running[2];
   bit m_vld  [2];
   int m_cnt  [2];
   bit m_alarm[2];
   bit m_sat  [2];
   bit m_part [2];
   bit m_ovf  [2];

   logic [13:0] obs_a, obs_b;

   always #5 clck = ~clck;

   seq_match_window_counter #(.WIN_LEN(16), .CNT_W(8), .THRESH(3)) u_dut_a (
      .clck(clck), .rst(rst), .en(en), .bit_vld(bit_vld), .det(det),
      .res_cnt(res_cnt_a), .res_vld(res_vld_a), .res_rdy(res_rdy),
      .res_alarm(res_alarm_a), .res_sat(res_sat_a), .res_part(res_part_a),
      .ovf(ovf_a), .busy(busy_a)
   );

   seq_match_window_counter #(.WIN_LEN(6), .CNT_W(2), .THRESH(3)) u_dut_b (
      .clck(clck), .rst(rst), .en(en), .bit_vld(bit_vld), .det(det),
      .res_cnt(res_cnt_b), .res_vld(res_vld_b), .res_rdy(res_rdy),
      .res_alarm(res_alarm_b), .res_sat(res_sat_b), .res_part(res_part_b),
      .ovf(ovf_b), .busy(busy_b)
   );

   // Result fields only carry meaning while valid, so they are masked otherwise.
   assign obs_a = {res_vld_a, res_vld_a ? {res_cnt_a, res_alarm_a, res_sat_a, res_part_a} : 11'd0,
                   ovf_a, busy_a};
   assign obs_b = {res_vld_b, res_vld_b ? {6'd0, res_cnt_b, res_alarm_b, res_sat_b, res_part_b} : 11'd0,
                   ovf_b, busy_b};

   function automatic logic [13:0] exp_vec(input int k);
      logic [7:0] c;
      c = 8'(m_cnt[k]);
      return {m_vld[k], m_vld[k] ? {c, m_alarm[k], m_sat[k], m_part[k]} : 11'd0, m_ovf[k], running[k]};
   endfunction

   // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after it.
   task automatic step(input bit r, input bit e, input bit v, input bit d, input bit rd);
      bit pub, pp;
      int pc;
      rst = r; en = e; bit_vld = v; det = d; res_rdy = rd;
      @(posedge clck);
      for (int k = 0; k < 2; k++) begin
         pub = 1'b0; pp = 1'b0; pc = 0;
         if (!r) begin
            running[k] = 1'b0; nbits[k] = 0; nmatch[k] = 0;
            m_vld[k] = 1'b0; m_cnt[k] = 0; m_alarm[k] = 1'b0;
            m_sat[k] = 1'b0; m_part[k] = 1'b0; m_ovf[k] = 1'b0;
         end else begin
            if (running[k] && !e) begin
               if (nbits[k] > 0) begin
                  pub = 1'b1; pc = nmatch[k]; pp = 1'b1;
               end
               running[k] = 1'b0; nbits[k] = 0; nmatch[k] = 0;
            end else if (e && v) begin
               running[k] = 1'b1;
               nbits[k]++;
               nmatch[k] += int'(d);
               if (nbits[k] == WINS[k]) begin
                  pub = 1'b1; pc = nmatch[k]; pp = 1'b0;
                  nbits[k] = 0; nmatch[k] = 0;
               end
            end
            if (pub) begin
               if (!m_vld[k] || rd) begin
                  m_vld[k]   = 1'b1;
                  m_cnt[k]   = (pc > MAXC[k]) ? MAXC[k] : pc;
                  m_sat[k]   = (pc > MAXC[k]);
                  m_alarm[k] = (m_cnt[k] >= THR);
                  m_part[k]  = pp;
               end else begin
                  m_ovf[k] = 1'b1;
               end
            end else if (m_vld[k] && rd) begin
               m_vld[k] = 1'b0;
            end
         end
      end
      #1;
   endtask

   task automatic feed(input int n, input logic [31:0] dmask, input bit rd);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, dmask[i], rd);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (obs_a !== 14'd0 || res_cnt_a !== 8'd0 || res_alarm_a !== 1'b0 || res_sat_a !== 1'b0 || res_part_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a: got vec=%h cnt=%0d, expected all zero", obs_a, res_cnt_a);
      end
      n_checks++;
      if (obs_b !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_b: got %h, expected 0", obs_b);
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (busy_a !== 1'b1 || res_vld_a !== 1'b0) begin
         n_fail++;
         $display("FAIL first_sample_busy: got busy=%b vld=%b, expected busy=1 vld=0", busy_a, res_vld_a);
      end
   endtask

   task automatic test_single_window();
      do_reset();
      feed(16, 32'h0000_8088, 1'b1);
      n_checks++;
      if (res_vld_a !== 1'b1 || res_cnt_a !== 8'd3 || res_alarm_a !== 1'b1 || res_part_a !== 1'b0 || res_sat_a !== 1'b0) begin
         n_fail++;
         $display("FAIL window_close: got vld=%b cnt=%0d alarm=%b part=%b sat=%b, expected 1 3 1 0 0",
                  res_vld_a, res_cnt_a, res_alarm_a, res_part_a, res_sat_a);
      end
      n_checks++;
      if (obs_b !== exp_vec(1)) begin
         n_fail++;
         $display("FAIL window_close_b: got %h, expected %h", obs_b, exp_vec(1));
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (res_vld_a !== 1'b0 || busy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL no_gap_bit16: got vld=%b busy=%b, expected vld=0 busy=1", res_vld_a, busy_a);
      end
      feed(15, 32'h0, 1'b1);
      n_checks++;
      if (res_vld_a !== 1'b1 || res_cnt_a !== 8'd1 || res_alarm_a !== 1'b0) begin
         n_fail++;
         $display("FAIL window2: got vld=%b cnt=%0d alarm=%b, expected 1 1 0", res_vld_a, res_cnt_a, res_alarm_a);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      feed(16, 32'h0000_0101, 1'b0);
      n_checks++;
      if (res_vld_a !== 1'b1 || res_cnt_a !== 8'd2 || ovf_a !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_first: got vld=%b cnt=%0d ovf=%b, expected 1 2 0", res_vld_a, res_cnt_a, ovf_a);
      end
      feed(16, 32'h0000_0020, 1'b0);
      n_checks++;
      if (res_cnt_a !== 8'd2 || ovf_a !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_second: got cnt=%0d ovf=%b, expected 2 1", res_cnt_a, ovf_a);
      end
      feed(16, 32'h0000_001E, 1'b0);
      n_checks++;
      if (res_vld_a !== 1'b1 || res_cnt_a !== 8'd2 || ovf_a !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_third_hold: got vld=%b cnt=%0d ovf=%b, expected 1 2 1", res_vld_a, res_cnt_a, ovf_a);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (res_vld_a !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_consume: got vld=%b, expected 0", res_vld_a);
      end
      feed(16, 32'h0000_8088, 1'b1);
      n_checks++;
      if (res_vld_a !== 1'b1 || res_cnt_a !== 8'd3 || ovf_a !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_window4: got vld=%b cnt=%0d ovf=%b, expected 1 3 1", res_vld_a, res_cnt_a, ovf_a);
      end
      n_checks++;
      if (obs_b !== exp_vec(1)) begin
         n_fail++;
         $display("FAIL ovf_b: got %h, expected %h", obs_b, exp_vec(1));
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      feed(16, 32'h0000_0101, 1'b0);
      feed(15, 32'h0000_001F, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (res_vld_a !== 1'b1 || res_cnt_a !== 8'd5 || ovf_a !== 1'b0) begin
         n_fail++;
         $display("FAIL back_to_back: got vld=%b cnt=%0d ovf=%b, expected 1 5 0", res_vld_a, res_cnt_a, ovf_a);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      feed(6, 32'h0000_001F, 1'b1);
      n_checks++;
      if (res_vld_b !== 1'b1 || res_cnt_b !== 2'd3 || res_sat_b !== 1'b1 || res_alarm_b !== 1'b1 || res_part_b !== 1'b0) begin
         n_fail++;
         $display("FAIL saturation: got vld=%b cnt=%0d sat=%b alarm=%b part=%b, expected 1 3 1 1 0",
                  res_vld_b, res_cnt_b, res_sat_b, res_alarm_b, res_part_b);
      end
      n_checks++;
      if (obs_a !== exp_vec(0)) begin
         n_fail++;
         $display("FAIL saturation_a: got %h, expected %h", obs_a, exp_vec(0));
      end
   endtask

   task automatic test_en_drop();
      do_reset();
      feed(5, 32'h0000_0004, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (res_vld_a !== 1'b1 || res_cnt_a !== 8'd1 || res_part_a !== 1'b1 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL en_drop: got vld=%b cnt=%0d part=%b busy=%b, expected 1 1 1 0",
                  res_vld_a, res_cnt_a, res_part_a, busy_a);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (res_vld_a !== 1'b0 || busy_a !== 1'b0 || res_vld_b !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_toggle: got vld_a=%b busy_a=%b vld_b=%b, expected 0 0 0", res_vld_a, busy_a, res_vld_b);
      end
      feed(16, 32'h0000_0001, 1'b0);
      feed(16, 32'h0000_0001, 1'b0);
      feed(3, 32'h0, 1'b0);
      n_checks++;
      if ({res_vld_a, ovf_a, busy_a} !== 3'b111) begin
         n_fail++;
         $display("FAIL pre_reset_state: got vld/ovf/busy=%b, expected 111", {res_vld_a, ovf_a, busy_a});
      end
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (obs_a !== 14'd0 || obs_b !== 14'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got a=%h b=%h, expected 0 0", obs_a, obs_b);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         n_checks++;
         if (res_vld_a !== 1'b0 || res_vld_b !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_publish: got vld_a=%b vld_b=%b, expected 0 0", res_vld_a, res_vld_b);
         end
      end
   endtask

   task automatic test_random();
      bit r, e, v, d, rd;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 199) != 0);
         e  = ($urandom_range(0, 19) != 0);
         v  = ($urandom_range(0, 9) < 7);
         d  = ($urandom_range(0, 9) < 4);
         rd = ($urandom_range(0, 9) < 4);
         step(r, e, v, d, rd);
         n_checks++;
         if (obs_a !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL random_a cycle %0d: got %h, expected %h", i, obs_a, exp_vec(0));
         end
         n_checks++;
         if (obs_b !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL random_b cycle %0d: got %h, expected %h", i, obs_b, exp_vec(1));
         end
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; bit_vld = 1'b0; det = 1'b0; res_rdy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         nbits[k] = 0; nmatch[k] = 0; running[k] = 1'b0; m_vld[k] = 1'b0; m_cnt[k] = 0;
         m_alarm[k] = 1'b0; m_sat[k] = 1'b0; m_part[k] = 1'b0; m_ovf[k] = 1'b0;
      end
      test_reset();
      test_single_window();
      test_overflow();
      test_back_to_back();
      test_saturation();
      test_en_drop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
